mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter between the fetch stage (IF) and the data access stage (EX/MEM) of the 5-stage MIPS core, for builds where instruction and data share one synchronous SRAM. Grants at most one access per cycle, data side first. A deferred fetch is replayed from an internal pending register. Each requester's read data is steered back and held stable between its own grants. Raises a stall request to the pipeline controller (CTRL) while a fetch is being deferred.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 32, width of conflict counter
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- inst_en  in  1  fetch request (from IF)
- inst_wen  in  4  fetch byte write enables (normally 0; passed through if granted)
- inst_addr  in  ADDR_W  fetch address
- inst_wdata  in  DATA_W  fetch write data
- inst_rdata  out  DATA_W  fetch read data to ID
- data_en  in  1  data request (from EX)
- data_wen  in  4  data byte write enables; 0 = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  data write data
- data_rdata  out  DATA_W  load data to MEM
- mem_en  out  1  shared SRAM enable
- mem_wen  out  4  shared SRAM byte write enables
- mem_addr  out  ADDR_W  shared SRAM address
- mem_wdata  out  DATA_W  shared SRAM write data
- mem_rdata  in  DATA_W  shared SRAM read data, valid the cycle after a read grant
- stallreq_for_mem  out  1  stall request to CTRL (freezes PC and IF/ID)
- conflict_cnt  out  CNT_W  saturating count of cycles in which a fetch was refused

## Operation
- There are two states:
  - IDLE: no fetch is pending.
  - PEND: a fetch is pending.
- Registers:
  - pend_addr, pend_wen, pend_wdata: the captured fetch.
  - last_owner: NONE, INST or DATA. Records the requester of the previous cycle's read grant; a grant with nonzero wen leaves it NONE.
  - inst_hold and data_hold: the most recent read data for each side.
- Grant in IDLE:
  - data_en=1: grant data.
  - data_en=0, inst_en=1: grant inst.
  - Neither: mem_en=0.
- Conflict in IDLE (inst_en and data_en both 1):
  - Data is granted.
  - The inst request is captured into the pend_* registers.
  - State moves to PEND.
  - stallreq_for_mem=1 and conflict_cnt increments.
- Grant in PEND:
  - data_en=1: data is granted again; the fetch stays pending; stallreq_for_mem=1 and conflict_cnt increments.
  - data_en=0: pend_addr/pend_wen/pend_wdata are granted, stallreq_for_mem=0, and state returns to IDLE.
  - The live inst_* inputs are ignored in PEND.
- mem_* outputs are combinational muxes of the granted request's fields. With no grant they are: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Read data steering:
  - inst_rdata = mem_rdata if last_owner==INST, else inst_hold.
  - data_rdata = mem_rdata if last_owner==DATA, else data_hold.
  - Each hold register loads mem_rdata in the cycle its side's last_owner is active.
- stallreq_for_mem = (IDLE & inst_en & data_en) | (PEND & data_en). It is combinational from the inputs and state.
- conflict_cnt saturates at all-ones and does not wrap.

## Timing
- Reset (rst=1 at a clk edge):
  - state=IDLE, last_owner=NONE.
  - pend_*, inst_hold, data_hold and conflict_cnt are cleared to 0.
  - The outputs then read: inst_rdata=0, data_rdata=0, stallreq_for_mem=0 (given data_en=0).
  - Reset while in PEND discards the pending fetch; no replay follows.
- Latency:
  - The grant cycle is zero added latency; the request appears on mem_* in the same cycle.
  - Read data appears on the requester's rdata one cycle after its grant, matching direct SRAM attachment.
- A deferred fetch is granted in the first cycle after the conflict with data_en=0. Its data appears one cycle later, and stall is already low in the grant cycle.
- Hold stability: inst_rdata is unchanged across data grants and idle cycles until the next inst read grant, and likewise for data_rdata.
- Writes: a granted write returns no data and leaves both hold registers and last_owner=NONE for the following cycle.
- Back-to-back data reads in IDLE with no fetch: every cycle is granted, and data_rdata tracks mem_rdata with one cycle of lag.
- inst_en dropping while in PEND has no effect; the replay still issues.

## Test plan
- Reset, then inst_en=1, addr=0xBFC00000, data_en=0 → mem_addr=0xBFC00000 in the same cycle; next cycle with mem_rdata=0x24080001, inst_rdata=0x24080001, stallreq=0.
- Conflict: inst addr 0xBFC00004 and data read addr 0x80001000 in cycle N:
  - Cycle N: mem_addr=0x80001000, stallreq=1.
  - Cycle N+1 (data_en=0): mem_addr=0xBFC00004, stallreq=0; data_rdata=mem_rdata=0x12345678.
  - Cycle N+2: inst_rdata=mem_rdata; conflict_cnt=1.
- Data request in PEND for 3 consecutive cycles → stallreq=1 throughout, conflict_cnt=4; on the first data_en=0 cycle, pend_addr is issued.
- Data write (wen=0xF, wdata=0xDEADBEEF) → mem_wen=0xF, mem_wdata=0xDEADBEEF; next cycle inst_rdata and data_rdata keep their prior hold values even if mem_rdata changes.
- Assert rst in the PEND cycle → next cycle with inst_en=0, data_en=0 gives mem_en=0, stallreq=0, conflict_cnt=0, and no replay.
- CNT_W=2: five conflicts → conflict_cnt=3, which holds.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data wins conflicts; the refused fetch is parked and replayed when data goes quiet.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [3:0]        inst_wen,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_for_mem,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {IDLE, PEND} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [3:0]        pend_wen_q, pend_wen_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
    logic [DATA_W-1:0] data_hold_q, data_hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = OWN_NONE;
        pend_addr_d  = pend_addr_q;
        pend_wen_d   = pend_wen_q;
        pend_wdata_d = pend_wdata_q;
        inst_hold_d  = inst_hold_q;
        data_hold_d  = data_hold_q;
        cnt_d        = cnt_q;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        stallreq_for_mem = 1'b0;

        if (data_en) begin
            mem_en    = 1'b1;
            mem_wen   = data_wen;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            owner_d   = (data_wen == 4'b0) ? OWN_DATA : OWN_NONE;
        end

        case (state_q)
            IDLE: begin
                if (inst_en && data_en) begin
                    stallreq_for_mem = 1'b1;
                    pend_addr_d  = inst_addr;
                    pend_wen_d   = inst_wen;
                    pend_wdata_d = inst_wdata;
                    state_d      = PEND;
                end else if (inst_en) begin
                    mem_en    = 1'b1;
                    mem_wen   = inst_wen;
                    mem_addr  = inst_addr;
                    mem_wdata = inst_wdata;
                    owner_d   = (inst_wen == 4'b0) ? OWN_INST : OWN_NONE;
                end
            end
            PEND: begin
                // Live inst_* are ignored here; only the parked fetch can be issued.
                if (data_en) begin
                    stallreq_for_mem = 1'b1;
                end else begin
                    mem_en    = 1'b1;
                    mem_wen   = pend_wen_q;
                    mem_addr  = pend_addr_q;
                    mem_wdata = pend_wdata_q;
                    owner_d   = (pend_wen_q == 4'b0) ? OWN_INST : OWN_NONE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stallreq_for_mem && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (owner_q == OWN_INST) inst_hold_d = mem_rdata;
        if (owner_q == OWN_DATA) data_hold_d = mem_rdata;
    end

    assign inst_rdata   = (owner_q == OWN_INST) ? mem_rdata : inst_hold_q;
    assign data_rdata   = (owner_q == OWN_DATA) ? mem_rdata : data_hold_q;
    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            pend_addr_q  <= '0;
            pend_wen_q   <= '0;
            pend_wdata_q <= '0;
            inst_hold_q  <= '0;
            data_hold_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            pend_addr_q  <= pend_addr_d;
            pend_wen_q   <= pend_wen_d;
            pend_wdata_q <= pend_wdata_d;
            inst_hold_q  <= inst_hold_d;
            data_hold_q  <= data_hold_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [3:0]  inst_wen;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stallreq_for_mem;
    logic [31:0] conflict_cnt;

    logic [31:0] s_inst_rdata, s_data_rdata, s_mem_addr, s_mem_wdata;
    logic        s_mem_en, s_stall;
    logic [3:0]  s_mem_wen;
    logic [1:0]  sat_cnt;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq_for_mem(stallreq_for_mem), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(s_inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(s_data_rdata),
        .mem_en(s_mem_en), .mem_wen(s_mem_wen), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .stallreq_for_mem(s_stall), .conflict_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {K_MEN, K_MADDR, K_MWEN, K_MWDATA, K_STALL, K_IRD, K_DRD, K_CNT, K_SAT} kind_e;
    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] actual(kind_e k);
        case (k)
            K_MEN:    return {31'b0, mem_en};
            K_MADDR:  return mem_addr;
            K_MWEN:   return {28'b0, mem_wen};
            K_MWDATA: return mem_wdata;
            K_STALL:  return {31'b0, stallreq_for_mem};
            K_IRD:    return inst_rdata;
            K_DRD:    return data_rdata;
            K_CNT:    return conflict_cnt;
            K_SAT:    return {30'b0, sat_cnt};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                a = actual(e.kind);
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, a, e.val, cyc);
                end
            end
        end
    end

    task automatic expect_v(kind_e k, logic [31:0] v, string n);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic drive(logic ien, logic [31:0] iaddr, logic den, logic [3:0] dwen,
                         logic [31:0] daddr, logic [31:0] dwdata, logic [31:0] mrd);
        inst_en = ien; inst_wen = 4'h0; inst_addr = iaddr; inst_wdata = 32'h0;
        data_en = den; data_wen = dwen; data_addr = daddr; data_wdata = dwdata;
        mem_rdata = mrd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        tick; tick;
        rst = 1'b0;

        // reset state
        expect_v(K_IRD, 32'h0, "rst_inst_rdata");
        expect_v(K_DRD, 32'h0, "rst_data_rdata");
        expect_v(K_STALL, 32'h0, "rst_stall");
        expect_v(K_CNT, 32'h0, "rst_cnt");
        expect_v(K_MEN, 32'h0, "rst_mem_en");
        tick;

        // plain fetch, same-cycle grant, data one cycle later
        drive(1, 32'hBFC0_0000, 0, 0, 0, 0, 32'h0);
        expect_v(K_MEN, 32'h1, "fetch_mem_en");
        expect_v(K_MADDR, 32'hBFC0_0000, "fetch_mem_addr");
        expect_v(K_STALL, 32'h0, "fetch_stall");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'h2408_0001);
        expect_v(K_IRD, 32'h2408_0001, "fetch_rdata");
        expect_v(K_STALL, 32'h0, "fetch_rdata_stall");
        expect_v(K_MEN, 32'h0, "idle_mem_en");
        expect_v(K_MADDR, 32'h0, "idle_mem_addr");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'hFFFF_0000);
        expect_v(K_IRD, 32'h2408_0001, "idle_inst_hold");
        tick;

        // conflict then replay; live inst inputs ignored in PEND
        drive(1, 32'hBFC0_0004, 1, 4'h0, 32'h8000_1000, 0, 32'h0);
        expect_v(K_MADDR, 32'h8000_1000, "conf_mem_addr");
        expect_v(K_STALL, 32'h1, "conf_stall");
        tick;
        drive(1, 32'h0000_AAAA, 0, 0, 0, 0, 32'h1234_5678);
        expect_v(K_MADDR, 32'hBFC0_0004, "replay_mem_addr");
        expect_v(K_MEN, 32'h1, "replay_mem_en");
        expect_v(K_STALL, 32'h0, "replay_stall");
        expect_v(K_DRD, 32'h1234_5678, "conf_data_rdata");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'h8C09_0004);
        expect_v(K_IRD, 32'h8C09_0004, "replay_inst_rdata");
        expect_v(K_DRD, 32'h1234_5678, "data_hold");
        expect_v(K_CNT, 32'd1, "conf_cnt1");
        tick;

        // conflict followed by three data cycles while pending
        drive(1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_2000, 0, 32'h0);
        expect_v(K_STALL, 32'h1, "pend0_stall");
        expect_v(K_MADDR, 32'h8000_2000, "pend0_addr");
        tick;
        drive(0, 0, 1, 4'h0, 32'h8000_2004, 0, 32'h0);
        expect_v(K_STALL, 32'h1, "pend1_stall");
        expect_v(K_MADDR, 32'h8000_2004, "pend1_addr");
        expect_v(K_CNT, 32'd2, "pend1_cnt");
        tick;
        drive(0, 0, 1, 4'h0, 32'h8000_2008, 0, 32'h0);
        expect_v(K_STALL, 32'h1, "pend2_stall");
        expect_v(K_CNT, 32'd3, "pend2_cnt");
        tick;
        drive(0, 0, 1, 4'h0, 32'h8000_200C, 0, 32'h0);
        expect_v(K_STALL, 32'h1, "pend3_stall");
        expect_v(K_CNT, 32'd4, "pend3_cnt");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'h0000_D003);
        expect_v(K_MADDR, 32'hBFC0_0008, "pend_replay_addr");
        expect_v(K_STALL, 32'h0, "pend_replay_stall");
        expect_v(K_CNT, 32'd5, "pend_cnt5");
        expect_v(K_DRD, 32'h0000_D003, "pend_last_drd");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'h1F1F_0005);
        expect_v(K_IRD, 32'h1F1F_0005, "pend_replay_ird");
        tick;

        // data write: no data returned, holds untouched
        drive(0, 0, 1, 4'hF, 32'h8000_3000, 32'hDEAD_BEEF, 32'h0);
        expect_v(K_MWEN, 32'hF, "wr_mem_wen");
        expect_v(K_MWDATA, 32'hDEAD_BEEF, "wr_mem_wdata");
        expect_v(K_MADDR, 32'h8000_3000, "wr_mem_addr");
        expect_v(K_STALL, 32'h0, "wr_stall");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'h5555_5555);
        expect_v(K_IRD, 32'h1F1F_0005, "wr_inst_hold");
        expect_v(K_DRD, 32'h0000_D003, "wr_data_hold");
        tick;

        // back-to-back data reads
        drive(0, 0, 1, 4'h0, 32'h8000_5000, 0, 32'h0);
        expect_v(K_MEN, 32'h1, "b2b0_en");
        tick;
        drive(0, 0, 1, 4'h0, 32'h8000_5004, 0, 32'hA1A1_A1A1);
        expect_v(K_MADDR, 32'h8000_5004, "b2b1_addr");
        expect_v(K_DRD, 32'hA1A1_A1A1, "b2b1_drd");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'hA2A2_A2A2);
        expect_v(K_DRD, 32'hA2A2_A2A2, "b2b2_drd");
        tick;
        drive(0, 0, 0, 0, 0, 0, 32'hA3A3_A3A3);
        expect_v(K_DRD, 32'hA2A2_A2A2, "b2b3_hold");
        expect_v(K_IRD, 32'h1F1F_0005, "b2b3_ihold");
        tick;

        // reset while pending discards the fetch
        drive(1, 32'hBFC0_000C, 1, 4'h0, 32'h8000_4000, 0, 32'h0);
        expect_v(K_STALL, 32'h1, "rp_conf_stall");
        tick;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        expect_v(K_CNT, 32'd6, "rp_cnt6");
        tick;
        rst = 1'b0;
        expect_v(K_MEN, 32'h0, "rp_mem_en");
        expect_v(K_STALL, 32'h0, "rp_stall");
        expect_v(K_CNT, 32'h0, "rp_cnt0");
        expect_v(K_IRD, 32'h0, "rp_ird0");
        expect_v(K_DRD, 32'h0, "rp_drd0");
        tick;
        expect_v(K_MEN, 32'h0, "rp_no_replay");
        tick;

        // five conflicts: 32-bit counter counts, 2-bit counter saturates
        for (int k = 1; k <= 5; k++) begin
            drive(1, 32'hBFC0_1000 + 32'(k), 1, 4'h0, 32'h8000_6000 + 32'(k), 0, 32'h0);
            tick;
            drive(0, 0, 0, 0, 0, 0, 32'h0);
            expect_v(K_CNT, 32'(k), "sat_main_cnt");
            expect_v(K_SAT, (k > 3) ? 32'd3 : 32'(k), "sat_cnt");
            tick;
        end
        expect_v(K_SAT, 32'd3, "sat_hold");
        expect_v(K_CNT, 32'd5, "sat_main_final");
        tick;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
